// File: rtl/gemm_bram_engine_pkg.sv
// Shared definitions for the GEMM engine: FSM state encoding, control
// register byte offsets and the MODE / STATUS / CTRL bit positions.
package gemm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_e;

    localparam logic [31:0] REG_CTRL   = 32'h00;
    localparam logic [31:0] REG_MODE   = 32'h04;
    localparam logic [31:0] REG_M      = 32'h08;
    localparam logic [31:0] REG_K      = 32'h0C;
    localparam logic [31:0] REG_N      = 32'h10;
    localparam logic [31:0] REG_STATUS = 32'h14;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned MODE_ACC_BIT   = 0;
    localparam int unsigned MODE_SGN_BIT   = 1;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_DONE_BIT  = 1;
    localparam int unsigned STAT_ERR_BIT   = 2;

endpackage

// File: rtl/gemm_bram_engine_if.sv
// Host-side bus of the GEMM engine.
//   sp_*  : control register port (write + combinational read)
//   a_*   : write port of operand memory A
//   w_*   : write port of operand memory W
//   O_*   : combinational read port of result memory O
// master = host, slave = engine.
interface gemm_bram_engine_if;

    logic [31:0] sp_addr;
    logic [31:0] sp_data_in;
    logic [3:0]  sp_web;
    logic [31:0] sp_data_out;

    logic [31:0] a_addr;
    logic [31:0] a_data_in;
    logic [3:0]  a_web;

    logic [31:0] w_addr;
    logic [31:0] w_data_in;
    logic [3:0]  w_web;

    logic [31:0] O_addr;
    logic [31:0] O_data;

    modport master (
        output sp_addr, sp_data_in, sp_web,
        output a_addr, a_data_in, a_web,
        output w_addr, w_data_in, w_web,
        output O_addr,
        input  sp_data_out, O_data
    );

    modport slave (
        input  sp_addr, sp_data_in, sp_web,
        input  a_addr, a_data_in, a_web,
        input  w_addr, w_data_in, w_web,
        input  O_addr,
        output sp_data_out, O_data
    );

endinterface

// File: rtl/gemm_bram_engine_bram_sdp.sv
// Simple dual-port block RAM: one write port, one synchronous read port
// (1-cycle latency, returns old data on a same-address collision).
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata valid the cycle after raddr
// Contents are never reset.
module bram_sdp #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/gemm_bram_engine.sv
// GEMM engine: O = A x W (+ O when accumulating) over up to MAX_DIM^3
// elements, one multiply-accumulate per cycle from block RAMs.
//   clk   : clock
//   reset : synchronous active-high reset (memories keep contents)
//   bus   : host control registers, A/W write ports, O read port
module gemm_bram_engine
    import gemm_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned MAX_DIM = 8
) (
    input  logic              clk,
    input  logic              reset,
    gemm_bram_engine_if.slave bus
);

    localparam int unsigned DEPTH = MAX_DIM * MAX_DIM;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(MAX_DIM + 1);

    state_e            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]        mode_q, mode_d;
    logic [31:0]       dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
    logic [CW-1:0]     i_q, i_d, j_q, j_d, kk_q, kk_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              pv_q, pv_d, ov_q, ov_d;

    logic              sp_we, start, dims_ok, last_i, last_j, last_k, o_we;
    logic [AW-1:0]     a_raddr, w_raddr, o_idx;
    logic [DATA_W-1:0] a_rdata, w_rdata;
    logic [ACC_W-1:0]  o_rdata, a_ext, w_ext, prod;
    logic [31:0]       o_wdata_ext;
    logic [31:0]       o_host_mem [DEPTH];
    logic              addr_unused;

    assign sp_we = |bus.sp_web;
    assign start = sp_we && (bus.sp_addr == REG_CTRL) && bus.sp_data_in[CTRL_START_BIT];

    assign dims_ok = (dim_m_q != 32'd0) && (dim_m_q <= 32'(MAX_DIM)) &&
                     (dim_k_q != 32'd0) && (dim_k_q <= 32'(MAX_DIM)) &&
                     (dim_n_q != 32'd0) && (dim_n_q <= 32'(MAX_DIM));
    assign last_i  = (32'(i_q)  == dim_m_q - 32'd1);
    assign last_j  = (32'(j_q)  == dim_n_q - 32'd1);
    assign last_k  = (32'(kk_q) == dim_k_q - 32'd1);

    // Row-major element indices; dims are bounded by MAX_DIM once running.
    assign a_raddr = AW'(i_q)  * AW'(dim_k_q) + AW'(kk_q);
    assign w_raddr = AW'(kk_q) * AW'(dim_n_q) + AW'(j_q);
    assign o_idx   = AW'(i_q)  * AW'(dim_n_q) + AW'(j_q);

    assign o_we = (state_q == S_WRITE) && !reset;

    // Operand extension and wrap-around product in the accumulator width.
    assign a_ext = mode_q[MODE_SGN_BIT] ? ACC_W'($signed(a_rdata)) : ACC_W'(a_rdata);
    assign w_ext = mode_q[MODE_SGN_BIT] ? ACC_W'($signed(w_rdata)) : ACC_W'(w_rdata);
    assign prod  = a_ext * w_ext;
    assign o_wdata_ext = mode_q[MODE_SGN_BIT] ? 32'($signed(acc_q)) : 32'(acc_q);

    bram_sdp #(.WIDTH(DATA_W), .DEPTH(DEPTH), .ADDR_W(AW)) u_a_mem (
        .clk   (clk),
        .we    (|bus.a_web),
        .waddr (bus.a_addr[AW+1:2]),
        .wdata (DATA_W'(bus.a_data_in)),
        .raddr (a_raddr),
        .rdata (a_rdata)
    );

    bram_sdp #(.WIDTH(DATA_W), .DEPTH(DEPTH), .ADDR_W(AW)) u_w_mem (
        .clk   (clk),
        .we    (|bus.w_web),
        .waddr (bus.w_addr[AW+1:2]),
        .wdata (DATA_W'(bus.w_data_in)),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    bram_sdp #(.WIDTH(ACC_W), .DEPTH(DEPTH), .ADDR_W(AW)) u_o_mem (
        .clk   (clk),
        .we    (o_we),
        .waddr (o_idx),
        .wdata (acc_q),
        .raddr (o_idx),
        .rdata (o_rdata)
    );

    // Host-visible copy of O, written alongside u_o_mem, read combinationally.
    always_ff @(posedge clk) begin
        if (o_we) begin
            o_host_mem[o_idx] <= o_wdata_ext;
        end
    end

    assign bus.O_data = o_host_mem[bus.O_addr[AW+1:2]];

    assign addr_unused = ^{bus.a_addr, bus.a_data_in, bus.w_addr, bus.w_data_in, bus.O_addr};

    // Control register read mux.
    always_comb begin
        bus.sp_data_out = 32'd0;
        case (bus.sp_addr)
            REG_MODE:   bus.sp_data_out = {30'd0, mode_q};
            REG_M:      bus.sp_data_out = dim_m_q;
            REG_K:      bus.sp_data_out = dim_k_q;
            REG_N:      bus.sp_data_out = dim_n_q;
            REG_STATUS: bus.sp_data_out = {29'd0, err_q, done_q, busy_q};
            default:    bus.sp_data_out = 32'd0;
        endcase
    end

    // Next-state logic: register writes, FSM sequencing and MAC pipeline.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        mode_d  = mode_q;
        dim_m_d = dim_m_q;
        dim_k_d = dim_k_q;
        dim_n_d = dim_n_q;
        i_d     = i_q;
        j_d     = j_q;
        kk_d    = kk_q;
        pv_d    = 1'b0;
        ov_d    = 1'b0;

        // Read data lands one cycle after issue; fold it in as it arrives.
        acc_d = acc_q;
        if (pv_q) acc_d = acc_d + prod;
        if (ov_q) acc_d = acc_d + o_rdata;

        if (sp_we && !busy_q) begin
            case (bus.sp_addr)
                REG_MODE: mode_d  = bus.sp_data_in[1:0];
                REG_M:    dim_m_d = bus.sp_data_in;
                REG_K:    dim_k_d = bus.sp_data_in;
                REG_N:    dim_n_d = bus.sp_data_in;
                default:  ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_CHECK: begin
                if (!dims_ok) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    i_d     = '0;
                    j_d     = '0;
                    kk_d    = '0;
                    acc_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                pv_d = 1'b1;
                ov_d = (kk_q == '0) && mode_q[MODE_ACC_BIT];
                if (last_k) begin
                    kk_d    = '0;
                    state_d = S_DRAIN;
                end else begin
                    kk_d = kk_q + CW'(1);
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                acc_d   = '0;
                state_d = S_MAC;
                if (last_j) begin
                    j_d = '0;
                    if (last_i) begin
                        i_d     = '0;
                        state_d = S_FIN;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= '0;
            dim_m_q <= '0;
            dim_k_q <= '0;
            dim_n_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            kk_q    <= '0;
            acc_q   <= '0;
            pv_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
            dim_m_q <= dim_m_d;
            dim_k_q <= dim_k_d;
            dim_n_q <= dim_n_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kk_q    <= kk_d;
            acc_q   <= acc_d;
            pv_q    <= pv_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_gemm_bram_engine.sv
// Bench for gemm_bram_engine: directed runs, expected values queued by the
// stimulus and checked by a negedge monitor against O_data / sp_data_out.
module tb_gemm_bram_engine;
    import gemm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gemm_bram_engine_if bus();

    gemm_bram_engine #(.DATA_W(8), .ACC_W(32), .MAX_DIM(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] exp_q [$];
    bit          sel_q [$];
    string       tag_q [$];
    logic        chk_req;
    int          total;
    int          bad;

    logic [31:0] mon_exp;
    logic [31:0] mon_act;
    bit          mon_sel;
    string       mon_tag;

    // Monitor: pops one expectation per presented read.
    always @(negedge clk) begin
        if (chk_req) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: read presented with nothing expected");
            end else begin
                mon_exp = exp_q.pop_front();
                mon_sel = sel_q.pop_front();
                mon_tag = tag_q.pop_front();
                mon_act = mon_sel ? bus.O_data : bus.sp_data_out;
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got %08h expected %08h", mon_tag, mon_act, mon_exp);
                end
            end
        end
    end

    task automatic sp_write(input logic [31:0] addr, input logic [31:0] data);
        bus.sp_addr    = addr;
        bus.sp_data_in = data;
        bus.sp_web     = 4'hF;
        @(posedge clk); #1;
        bus.sp_web     = 4'h0;
    endtask

    task automatic aw_write(input int idx, input logic [31:0] a, input logic [31:0] w);
        bus.a_addr    = 32'(idx * 4);
        bus.a_data_in = a;
        bus.a_web     = 4'h1;
        bus.w_addr    = 32'(idx * 4);
        bus.w_data_in = w;
        bus.w_web     = 4'h8;
        @(posedge clk); #1;
        bus.a_web     = 4'h0;
        bus.w_web     = 4'h0;
    endtask

    task automatic cfg(input logic [31:0] mode, input logic [31:0] m,
                       input logic [31:0] k, input logic [31:0] n);
        sp_write(REG_MODE, mode);
        sp_write(REG_M, m);
        sp_write(REG_K, k);
        sp_write(REG_N, n);
    endtask

    task automatic check_sp(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus.sp_addr = addr;
        exp_q.push_back(exp);
        sel_q.push_back(1'b0);
        tag_q.push_back(tag);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic check_o(input int idx, input logic [31:0] exp, input string tag);
        bus.O_addr = 32'(idx * 4);
        exp_q.push_back(exp);
        sel_q.push_back(1'b1);
        tag_q.push_back($sformatf("%s[%0d]", tag, idx));
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        bus.sp_addr = REG_STATUS;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (bus.sp_data_out[STAT_DONE_BIT]) seen = 1'b1;
            @(posedge clk); #1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: done not seen within %0d cycles", tag, budget);
        end
    endtask

    // Per-cycle STATUS trace for an error run: CHECK, FIN, then done+err.
    task automatic err_trace(input string tag);
        check_sp(REG_STATUS, 32'h1, {tag, "_c0"});
        check_sp(REG_STATUS, 32'h5, {tag, "_c1"});
        check_sp(REG_STATUS, 32'h6, {tag, "_c2"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        chk_req        = 1'b0;
        total          = 0;
        bad            = 0;
        reset          = 1'b1;
        bus.sp_addr    = '0;
        bus.sp_data_in = '0;
        bus.sp_web     = '0;
        bus.a_addr     = '0;
        bus.a_data_in  = '0;
        bus.a_web      = '0;
        bus.w_addr     = '0;
        bus.w_data_in  = '0;
        bus.w_web      = '0;
        bus.O_addr     = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state of the register file.
        check_sp(REG_STATUS, 32'h0, "rst_status");
        check_sp(REG_MODE,   32'h0, "rst_mode");
        check_sp(REG_M,      32'h0, "rst_m");
        check_sp(REG_K,      32'h0, "rst_k");
        check_sp(REG_N,      32'h0, "rst_n");
        check_sp(REG_CTRL,   32'h0, "ctrl_reads_zero");

        // All-ones 7x8x3: every O = 8.
        for (int x = 0; x < 64; x++) aw_write(x, 32'h1, 32'h1);
        cfg(32'h0, 32'd7, 32'd8, 32'd3);
        check_sp(REG_MODE, 32'h0, "mode_rb");
        check_sp(REG_K, 32'd8, "k_rb");
        sp_write(REG_CTRL, 32'h1);
        wait_done(400, "basic_done");
        for (int x = 0; x < 21; x++) check_o(x, 32'd8, "o_basic");
        check_sp(REG_STATUS, 32'h2, "basic_status");

        // Accumulate rerun: exact latency 2+21*10, with an ignored restart
        // and an ignored M write mid-run.
        sp_write(REG_MODE, 32'h1);
        sp_write(REG_CTRL, 32'h1);
        for (int c = 0; c <= 212; c++) begin
            if (c == 5) sp_write(REG_CTRL, 32'h1);
            else if (c == 7) sp_write(REG_M, 32'd2);
            else check_sp(REG_STATUS, (c < 212) ? 32'h1 : 32'h2, $sformatf("acc_lat_c%0d", c));
        end
        check_sp(REG_M, 32'd7, "m_locked_while_busy");
        check_sp(REG_MODE, 32'h1, "mode_acc_rb");
        for (int x = 0; x < 21; x++) check_o(x, 32'd16, "o_acc");

        // 3x4x2: done exactly 38 cycles after start, busy throughout.
        cfg(32'h0, 32'd3, 32'd4, 32'd2);
        sp_write(REG_CTRL, 32'h1);
        for (int c = 0; c <= 38; c++)
            check_sp(REG_STATUS, (c < 38) ? 32'h1 : 32'h2, $sformatf("lat38_c%0d", c));
        check_o(0, 32'd4, "o_342");
        check_o(5, 32'd4, "o_342");
        check_o(6, 32'd16, "o_342_untouched");
        check_o(20, 32'd16, "o_342_untouched");

        // Signed vs unsigned: A=0xFF, W=2, K=4.
        for (int x = 0; x < 4; x++) aw_write(x, 32'hFF, 32'h2);
        cfg(32'h2, 32'd1, 32'd4, 32'd1);
        sp_write(REG_CTRL, 32'h1);
        wait_done(100, "signed_done");
        check_o(0, 32'hFFFF_FFF8, "o_signed");
        sp_write(REG_MODE, 32'h0);
        sp_write(REG_CTRL, 32'h1);
        wait_done(100, "unsigned_done");
        check_o(0, 32'h0000_07F8, "o_unsigned");
        check_o(1, 32'd4, "o_unsigned_neighbour");

        // Error runs: M=0, then K above MAX_DIM.
        sp_write(REG_M, 32'd0);
        sp_write(REG_CTRL, 32'h1);
        err_trace("err_m0");
        check_o(0, 32'h0000_07F8, "o_after_err_m0");
        sp_write(REG_M, 32'd1);
        sp_write(REG_K, 32'd9);
        check_sp(REG_K, 32'd9, "k9_rb");
        sp_write(REG_CTRL, 32'h1);
        err_trace("err_k9");
        check_o(0, 32'h0000_07F8, "o_after_err_k9");

        // Largest legal M and N with K=1: every O = 1.
        for (int x = 0; x < 4; x++) aw_write(x, 32'h1, 32'h1);
        cfg(32'h0, 32'd8, 32'd1, 32'd8);
        sp_write(REG_CTRL, 32'h1);
        wait_done(400, "max_done");
        check_o(0, 32'd1, "o_max");
        check_o(27, 32'd1, "o_max");
        check_o(63, 32'd1, "o_max");
        check_sp(REG_STATUS, 32'h2, "max_status");

        // Reset 10 cycles into a 7x8x3 accumulate run, before any O write.
        cfg(32'h1, 32'd7, 32'd8, 32'd3);
        sp_write(REG_CTRL, 32'h1);
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_sp(REG_STATUS, 32'h0, "abort_status");
        check_sp(REG_MODE,   32'h0, "abort_mode");
        check_sp(REG_M,      32'h0, "abort_m");
        check_sp(REG_K,      32'h0, "abort_k");
        check_sp(REG_N,      32'h0, "abort_n");
        check_o(0, 32'd1, "o_abort_kept");
        check_o(20, 32'd1, "o_abort_kept");
        check_o(63, 32'd1, "o_abort_kept");

        @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: %0d expectations never checked", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
